fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 25 ++
 rtl/fetch_stage.sv | 108 ++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction fetch stage bus: PC/imem side inputs, imem request and IF/ID outputs
interface fetch_stage_if;
    logic [31:0] pcout;
    logic        ihit;
    logic [31:0] imemload;
    logic        stall;
    logic        flush;
    logic        halt;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        pcenable;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_npc;
    logic        ifid_valid;

    modport slave (
        input  pcout, ihit, imemload, stall, flush, halt,
        output imemREN, imemaddr, pcenable, ifid_instr, ifid_npc, ifid_valid
    );

    modport master (
        output pcout, ihit, imemload, stall, flush, halt,
        input  imemREN, imemaddr, pcenable, ifid_instr, ifid_npc, ifid_valid
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - fetch stage FSM with one-word stall buffer feeding the IF/ID register
module fetch_stage (
    input  logic          CLK,
    input  logic          nRST,
    fetch_stage_if.slave  bus
);
    typedef enum logic [1:0] {S_FETCH, S_HOLD, S_HALTED} state_t;

    state_t      state, next_state;
    logic [31:0] buf_instr, buf_addr;
    logic [31:0] instr_q, npc_q;
    logic        valid_q;

    logic        pcen;
    logic        ifid_load;
    logic [31:0] ifid_instr_d, ifid_npc_d;
    logic        ifid_valid_d;
    logic        buf_load, buf_clear;

    always_comb begin
        next_state   = state;
        pcen         = 1'b0;
        ifid_load    = 1'b0;
        ifid_instr_d = 32'd0;
        ifid_npc_d   = npc_q;
        ifid_valid_d = 1'b0;
        buf_load     = 1'b0;
        buf_clear    = 1'b0;

        // halt wins over everything; the word returned this cycle is dropped
        if (bus.halt) begin
            next_state = S_HALTED;
        end else begin
            case (state)
                S_FETCH: begin
                    if (bus.flush) begin
                        ifid_load = 1'b1;
                        pcen      = 1'b1;
                        buf_clear = 1'b1;
                    end else if (bus.stall) begin
                        if (bus.ihit) begin
                            buf_load   = 1'b1;
                            next_state = S_HOLD;
                        end
                    end else if (bus.ihit) begin
                        ifid_load    = 1'b1;
                        ifid_instr_d = bus.imemload;
                        ifid_npc_d   = bus.pcout + 32'd4;
                        ifid_valid_d = 1'b1;
                        pcen         = 1'b1;
                    end else begin
                        ifid_load = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (bus.flush) begin
                        ifid_load  = 1'b1;
                        pcen       = 1'b1;
                        buf_clear  = 1'b1;
                        next_state = S_FETCH;
                    end else if (!bus.stall) begin
                        ifid_load    = 1'b1;
                        ifid_instr_d = buf_instr;
                        ifid_npc_d   = buf_addr + 32'd4;
                        ifid_valid_d = 1'b1;
                        pcen         = 1'b1;
                        buf_clear    = 1'b1;
                        next_state   = S_FETCH;
                    end
                end
                default: next_state = S_HALTED;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= S_FETCH;
            instr_q   <= 32'd0;
            npc_q     <= 32'd0;
            valid_q   <= 1'b0;
            buf_instr <= 32'd0;
            buf_addr  <= 32'd0;
        end else begin
            state <= next_state;
            if (ifid_load) begin
                instr_q <= ifid_instr_d;
                npc_q   <= ifid_npc_d;
                valid_q <= ifid_valid_d;
            end
            if (buf_load) begin
                buf_instr <= bus.imemload;
                buf_addr  <= bus.pcout;
            end else if (buf_clear) begin
                buf_instr <= 32'd0;
                buf_addr  <= 32'd0;
            end
        end
    end

    // request/strobe are gated by nRST so nothing escapes while reset is held
    assign bus.imemREN    = nRST && (state == S_FETCH);
    assign bus.imemaddr   = (state == S_HOLD) ? buf_addr : bus.pcout;
    assign bus.pcenable   = nRST && pcen;
    assign bus.ifid_instr = instr_q;
    assign bus.ifid_npc   = npc_q;
    assign bus.ifid_valid = valid_q;
endmodule
